// File: rtl/mac_dot_engine.sv
// mac_dot_engine: multi-lane multiply-accumulate dot-product engine
// Ports:
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   clear                  synchronous abort: back to IDLE with accumulator zeroed
//   start, len, signed_mode  begin a dot product of len beats (0 means 1), mode latched
//   in_valid/in_ready      operand beat handshake, a_vec/b_vec carry LANES packed operands
//   out_valid/out_ready    result handshake, result mirrors the accumulator
//   overflow               sticky out-of-range flag for the current dot product
//   busy                   engine is not idle
module mac_dot_engine #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      start,
    input  logic [LEN_W-1:0]          len,
    input  logic                      signed_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   a_vec,
    input  logic [LANES*DATA_W-1:0]   b_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          result,
    output logic                      overflow,
    output logic                      busy
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + $clog2(LANES) + 1;
    // Wide enough to hold accumulator plus every lane product exactly, with headroom for range tests
    localparam int EW = (ACC_W > SW ? ACC_W : SW) + 2;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  remain_q;
    logic              signed_q;
    logic              p_valid_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  acc_q;
    logic [PW-1:0]     prod_q [LANES];
    logic [PW-1:0]     prod_d [LANES];
    logic [EW-1:0]     sum_d;
    logic [EW-ACC_W:0] hi;
    logic              ovf_step;
    logic              accept;

    assign accept    = in_valid && state_q == ACCUM;
    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = acc_q;
    assign overflow  = ovf_q;

    // Extending both operands to full product width lets one multiplier serve both modes:
    // the low 2*DATA_W bits of the product are exact either way.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0] a_x, b_x;
        assign a_x = {{DATA_W{signed_q & a_vec[i*DATA_W+DATA_W-1]}}, a_vec[i*DATA_W +: DATA_W]};
        assign b_x = {{DATA_W{signed_q & b_vec[i*DATA_W+DATA_W-1]}}, b_vec[i*DATA_W +: DATA_W]};
        assign prod_d[i] = a_x * b_x;
    end

    always_comb begin
        sum_d = {{(EW-ACC_W){signed_q & acc_q[ACC_W-1]}}, acc_q};
        for (int i = 0; i < LANES; i++)
            sum_d = sum_d + {{(EW-PW){signed_q & prod_q[i][PW-1]}}, prod_q[i]};
    end

    // Signed results fit when the bits from ACC_W-1 upward are all equal;
    // unsigned results fit when the bits from ACC_W upward are all zero.
    assign hi       = sum_d[EW-1:ACC_W-1];
    assign ovf_step = signed_q ? !(&hi || !(|hi)) : |hi[EW-ACC_W:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            signed_q  <= 1'b0;
            p_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            prod_q    <= '{default: '0};
        end else if (clear) begin
            state_q   <= IDLE;
            p_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
        end else begin
            p_valid_q <= accept;
            if (accept)
                prod_q <= prod_d;
            if (p_valid_q) begin
                acc_q <= sum_d[ACC_W-1:0];
                if (ovf_step)
                    ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (start) begin
                    acc_q    <= '0;
                    ovf_q    <= 1'b0;
                    remain_q <= (len == '0) ? LEN_W'(1) : len;
                    signed_q <= signed_mode;
                    state_q  <= ACCUM;
                end
                ACCUM: if (accept) begin
                    remain_q <= remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1))
                        state_q <= DRAIN;
                end
                DRAIN:   state_q <= DONE;
                DONE:    if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: table, hand-written and randomized checks of mac_dot_engine (72- and 64-bit accumulators)
module tb_mac_dot_engine;
    localparam int DW = 32;
    localparam int L  = 4;
    localparam int LW = 16;

    logic clk = 0, reset_n = 0, clear = 0, start = 0, signed_mode = 0, in_valid = 0, out_ready = 0;
    logic [LW-1:0]   len = '0;
    logic [L*DW-1:0] a_vec = '0, b_vec = '0;
    logic            in_ready, out_valid, overflow, busy;
    logic [71:0]     result;
    logic            in_ready64, out_valid64, overflow64, busy64;
    logic [63:0]     result64;
    int              pass_cnt = 0, total_cnt = 0;
    logic [127:0]    ba [8];
    logic [127:0]    bb [8];

    typedef struct {
        bit           sm;
        int           n;
        logic [LW-1:0] lv;
        logic [127:0] a0, b0, a1, b1;
        logic [71:0]  e72;
        logic         o72;
        logic [63:0]  e64;
        logic         o64;
    } vec_t;
    vec_t tv [6];

    always #5 clk = ~clk;

    mac_dot_engine u_dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .len(len),
        .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    mac_dot_engine #(.ACC_W(64)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .len(len),
        .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready64),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid64), .out_ready(out_ready),
        .result(result64), .overflow(overflow64), .busy(busy64)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Exact-integer reference: sum each beat's lane products, range-test the running total, wrap to w bits.
    function automatic void model(input bit sm, input int n, input int w, output logic [127:0] res, output logic ovf);
        logic signed [191:0] acc, s, xa, xb, m, lo, hi, t;
        logic [31:0] ua, ub;
        acc = 0;
        ovf = 0;
        m   = 192'sd1 <<< w;
        lo  = sm ? -(m >>> 1) : 192'sd0;
        hi  = sm ? (m >>> 1) - 1 : m - 1;
        for (int b = 0; b < n; b++) begin
            s = acc;
            for (int l = 0; l < L; l++) begin
                ua = ba[b][l*DW +: DW];
                ub = bb[b][l*DW +: DW];
                xa = sm ? {{160{ua[31]}}, ua} : {160'b0, ua};
                xb = sm ? {{160{ub[31]}}, ub} : {160'b0, ub};
                s += xa * xb;
            end
            if (s < lo || s > hi) ovf = 1;
            t   = s & (m - 1);
            acc = (sm && t[w-1]) ? t - m : t;
        end
        t   = acc & (m - 1);
        res = t[127:0];
    endfunction

    function automatic logic [127:0] rnd_vec();
        logic [127:0] v;
        int k;
        for (int l = 0; l < L; l++) begin
            k = $urandom_range(0, 3);
            v[l*DW +: DW] = k == 0 ? 32'hFFFF_FFFF : k == 1 ? 32'h8000_0000 : $urandom();
        end
        return v;
    endfunction

    task automatic run_op(input bit sm, input int n, input logic [LW-1:0] lv, input int gap, input int hold,
                          input string nm, input logic [71:0] e72, input logic o72,
                          input logic [63:0] e64, input logic o64, output logic [71:0] r72);
        @(negedge clk);
        start = 1; len = lv; signed_mode = sm;
        @(negedge clk);
        start = 0; len = LW'($urandom()); signed_mode = ~sm;
        chk({nm, " busy"}, busy, 1);
        chk({nm, " ovf cleared"}, {overflow, overflow64}, 0);
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                in_valid = 0;
                a_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
                b_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
                @(negedge clk);
            end
            in_valid = 1; a_vec = ba[k]; b_vec = bb[k];
            chk({nm, " in_ready"}, in_ready, 1);
            @(negedge clk);
        end
        a_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk({nm, " drain out_valid"}, out_valid, 0);
        chk({nm, " drain in_ready"}, in_ready, 0);
        @(negedge clk);
        in_valid = 0;
        chk({nm, " out_valid"}, out_valid, 1);
        chk({nm, " result72"}, result, e72);
        chk({nm, " ovf72"}, overflow, o72);
        chk({nm, " result64"}, result64, e64);
        chk({nm, " ovf64"}, overflow64, o64);
        r72 = result;
        for (int h = 0; h < hold; h++) begin
            start = 1; in_valid = 1;
            @(negedge clk);
            chk({nm, " hold out_valid"}, out_valid, 1);
            chk({nm, " hold result"}, {result, overflow}, {e72, o72});
            chk({nm, " hold in_ready"}, in_ready, 0);
        end
        start = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({nm, " idle busy"}, {busy, out_valid}, 0);
    endtask

    initial begin
        logic [71:0]  r0, r1;
        logic [127:0] e72, e64;
        logic         o72, o64;
        bit           sm;
        int           n;

        tv[0] = '{0, 2, 2, 128'h00000004_00000003_00000002_00000001, 128'h00000008_00000007_00000006_00000005,
                  128'h00000001_00000001_00000001_00000001, 128'h00000001_00000001_00000001_00000001,
                  72'd74, 0, 64'd74, 0};
        tv[1] = '{1, 1, 1, 128'h00000000_00000000_00000003_FFFFFFFE, 128'h00000000_00000000_FFFFFFFC_00000005,
                  128'h0, 128'h0, 72'hFF_FFFF_FFFF_FFFF_FFEA, 0, 64'hFFFF_FFFF_FFFF_FFEA, 0};
        tv[2] = '{0, 1, 1, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 128'h0, 128'h0,
                  72'h03_FFFF_FFF8_0000_0004, 0, 64'hFFFF_FFF8_0000_0004, 1};
        tv[3] = '{1, 1, 1, {4{32'h8000_0000}}, {4{32'h8000_0000}}, 128'h0, 128'h0,
                  72'h01_0000_0000_0000_0000, 0, 64'h0, 1};
        tv[4] = '{0, 1, 0, 128'h7, 128'h6, 128'h0, 128'h0, 72'd42, 0, 64'd42, 0};
        tv[5] = '{1, 2, 2, {4{32'h8000_0000}}, {4{32'h8000_0000}}, 128'h1, 128'h1,
                  72'h01_0000_0000_0000_0001, 0, 64'h1, 1};

        #12;
        chk("reset outputs", {result, overflow, out_valid, in_ready, busy}, 0);
        chk("reset outputs64", {result64, overflow64, out_valid64, in_ready64, busy64}, 0);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 6; i++) begin
            ba[0] = tv[i].a0; bb[0] = tv[i].b0; ba[1] = tv[i].a1; bb[1] = tv[i].b1;
            run_op(tv[i].sm, tv[i].n, tv[i].lv, 0, 1, $sformatf("vec%0d", i),
                   tv[i].e72, tv[i].o72, tv[i].e64, tv[i].o64, r0);
        end

        // Bubbles and back-pressure must give the same answer as a gap-free run
        for (int k = 0; k < 3; k++) begin ba[k] = rnd_vec(); bb[k] = rnd_vec(); end
        model(0, 3, 72, e72, o72);
        model(0, 3, 64, e64, o64);
        run_op(0, 3, 3, 0, 0, "nogap", e72[71:0], o72, e64[63:0], o64, r0);
        run_op(0, 3, 3, 2, 5, "bubble", e72[71:0], o72, e64[63:0], o64, r1);
        chk("bubble vs nogap", r1, r0);

        // Clear in ACCUM after one of three beats
        ba[0] = rnd_vec(); bb[0] = rnd_vec();
        @(negedge clk);
        start = 1; len = 3; signed_mode = 0;
        @(negedge clk);
        start = 0; in_valid = 1; a_vec = ba[0]; b_vec = bb[0];
        @(negedge clk);
        in_valid = 0; clear = 1; start = 1;
        @(negedge clk);
        chk("clear state", {result, overflow, busy, in_ready, out_valid}, 0);
        @(negedge clk);
        clear = 0; start = 0;
        chk("clear beats start", busy, 0);
        ba[0] = rnd_vec(); bb[0] = rnd_vec();
        model(1, 1, 72, e72, o72);
        model(1, 1, 64, e64, o64);
        run_op(1, 1, 1, 0, 0, "after clear", e72[71:0], o72, e64[63:0], o64, r0);

        // Asynchronous reset while draining
        ba[0] = 128'h1; bb[0] = 128'h9; ba[1] = rnd_vec(); bb[1] = rnd_vec();
        @(negedge clk);
        start = 1; len = 2; signed_mode = 0;
        @(negedge clk);
        start = 0; in_valid = 1; a_vec = ba[0]; b_vec = bb[0];
        @(negedge clk);
        a_vec = ba[1]; b_vec = bb[1];
        @(negedge clk);
        in_valid = 0;
        chk("pre-reset drain", {busy, out_valid, result}, {1'b1, 1'b0, 72'd9});
        #2 reset_n = 0;
        #1;
        chk("async reset72", {result, overflow, out_valid, in_ready, busy}, 0);
        chk("async reset64", {result64, overflow64, out_valid64, in_ready64, busy64}, 0);
        @(negedge clk);
        reset_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post-reset quiet", {out_valid, out_valid64, busy}, 0);
        end

        // Randomized transactions against the reference model
        for (int t = 0; t < 16; t++) begin
            sm = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin ba[k] = rnd_vec(); bb[k] = rnd_vec(); end
            model(sm, n, 72, e72, o72);
            model(sm, n, 64, e64, o64);
            run_op(sm, n, LW'(n), $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rand%0d", t),
                   e72[71:0], o72, e64[63:0], o64, r0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mac_dot_engine.md
MAC_DOT_ENGINE -- requirements
Module: mac_dot_engine

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand width per lane.
REQ-002 SHALL provide parameter LANES, default 4, multiplier lanes per beat.
REQ-003 SHALL provide parameter ACC_W, default 72, accumulator width; legal range ACC_W >= 2*DATA_W.
REQ-004 SHALL provide parameter LEN_W, default 16, beat-count width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort/zero
- start  input  1  begin a dot product
- len  input  LEN_W  beats per dot product, sampled on start
- signed_mode  input  1  1 = two's-complement operands, sampled on start
- in_valid  input  1  operand beat valid
- in_ready  output  1  operand beat accepted when in_valid also high
- a_vec  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- b_vec  input  LANES*DATA_W  same packing
- out_valid  output  1  result available
- out_ready  input  1  result consumed
- result  output  ACC_W  accumulator value
- overflow  output  1  sticky range-overflow flag
- busy  output  1  high whenever state != IDLE

Function
REQ-006 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-007 In IDLE, start=1 SHALL zero the accumulator and overflow, latch len and signed_mode, and go to ACCUM; len=0 SHALL be treated as len=1.
REQ-008 in_ready SHALL be 1 only in ACCUM while beats remain; in_valid SHALL be ignored in all other states.
REQ-009 Each accepted beat SHALL form LANES full-width 2*DATA_W products, signed or unsigned per the latched mode, registered in stage 1.
REQ-010 Stage 2 SHALL add the sign/zero-extended sum of all lane products to the accumulator, truncated modulo 2^ACC_W.
REQ-011 overflow SHALL set when any accumulate step's exact result lies outside the ACC_W range: [-2^(ACC_W-1), 2^(ACC_W-1)-1] when signed, [0, 2^ACC_W-1] when unsigned. It SHALL remain set until the next start, clear or reset.
REQ-012 Bubbles on in_valid SHALL NOT alter the result; only accepted beats count.
REQ-013 Accepting the last beat at edge E0 SHALL move the state to DRAIN; at edge E1 the accumulator SHALL hold the final sum, state SHALL become DONE, and out_valid SHALL be 1. Latency is 2 cycles from last beat to out_valid.
REQ-014 In DONE, result and overflow SHALL hold stable while out_valid=1 and out_ready=0; out_valid&out_ready SHALL return the state to IDLE at the next edge.
REQ-015 result SHALL continuously drive the accumulator, and it is meaningful only when out_valid=1.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 clear=1 SHALL, at the next edge and in any state, go to IDLE and zero the accumulator, pipeline valid, overflow and out_valid; clear SHALL take priority over start, in_valid and out_ready in the same cycle.

Reset
REQ-018 reset_n=0 SHALL immediately, without a clock edge, force IDLE and drive result=0, overflow=0, out_valid=0, in_ready=0, busy=0, and clear pipeline registers, including mid-operation.
REQ-019 Operation SHALL resume on the first rising clk edge after reset_n deasserts, with no spurious out_valid.

Verification
REQ-020 Defaults, unsigned, len=2: beat1 a={1,2,3,4}, b={5,6,7,8}; beat2 a={1,1,1,1}, b={1,1,1,1} -> result=74, out_valid exactly 2 cycles after beat2, overflow=0.
REQ-021 Signed, len=1: a={-2,3,0,0}, b={5,-4,0,0} -> result=0xFFFFFFFFFFFFFFFFEA (-22), overflow=0.
REQ-022 ACC_W=64, unsigned, len=1, all lanes a=b=0xFFFFFFFF -> result=0xFFFFFFF800000004, overflow=1; a following start clears overflow to 0.
REQ-023 len=3 with in_valid bubbles of 2 cycles between beats, plus out_ready held low 5 cycles in DONE -> result identical to the gap-free run, result/out_valid stable throughout, start pulses ignored, in_ready=0.
REQ-024 clear asserted in ACCUM after 1 of 3 beats -> IDLE next cycle, result=0, busy=0; a new start with len=1 yields the correct fresh sum.
REQ-025 reset_n pulled low asynchronously during DRAIN -> result=0, out_valid=0, busy=0 before the next clk edge; no out_valid after release.
